// File: rtl/seg7_scan_counter.sv
// seg7_scan_counter: debounced up/down decimal counter with a sequential
// double-dabble BCD converter and a multiplexed NUM_DIGITS 7-segment display.
module seg7_scan_counter #(
  parameter int NUM_DIGITS     = 4,
  parameter int CNT_WIDTH      = 14,
  parameter int DEBOUNCE_CYC   = 100000,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_countUpClicked,
  input  logic                  i_countDnClicked,
  input  logic                  i_blankLZ,
  output logic [CNT_WIDTH-1:0]  o_count,
  output logic                  o_busy,
  output logic [NUM_DIGITS-1:0] o_digitSelect,
  output logic [7:0]            o_LED
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC);
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int IT_W  = $clog2(CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] MAX_COUNT = CNT_WIDTH'(10 ** NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} bcd_state_t;

  // Bit 0 is the up button, bit 1 is the down button.
  logic [1:0]            raw_btn;
  logic [1:0]            sync_a;
  logic [1:0]            sync_b;
  logic [1:0]            db_level;
  logic [1:0]            press_pulse;
  logic [DB_W-1:0]       db_cnt [2];

  logic [CNT_WIDTH-1:0]  count_q;

  bcd_state_t            state;
  logic [BCD_W-1:0]      bcd_work;
  logic [BCD_W-1:0]      bcd_adj;
  logic [CNT_WIDTH-1:0]  bin_work;
  logic [CNT_WIDTH-1:0]  snapshot;
  logic [IT_W-1:0]       iter;
  logic [BCD_W-1:0]      bcd_reg;

  logic [PS_W-1:0]       prescale;
  logic [IDX_W-1:0]      scan_idx;

  logic [3:0]            cur_nibble;
  logic                  cur_blank;
  logic [6:0]            cur_seg;
  logic [7:0]            led_next;
  logic [NUM_DIGITS-1:0] sel_next;

  assign raw_btn = {i_countDnClicked, i_countUpClicked};
  assign o_count = count_q;

  // Active-high segment pattern {g,f,e,d,c,b,a}; anything above 9 stays dark.
  function automatic logic [6:0] seg7_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Synchronise both buttons, accept a new level after DEBOUNCE_CYC differing samples, pulse on rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_a      <= '0;
      sync_b      <= '0;
      db_level    <= '0;
      press_pulse <= '0;
      for (int b = 0; b < 2; b++) db_cnt[b] <= '0;
    end else begin
      sync_a <= raw_btn;
      sync_b <= sync_a;
      for (int b = 0; b < 2; b++) begin
        press_pulse[b] <= 1'b0;
        if (sync_b[b] == db_level[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_W'(DEBOUNCE_CYC - 1)) begin
          db_cnt[b]      <= '0;
          db_level[b]    <= sync_b[b];
          press_pulse[b] <= sync_b[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  // Decimal-wrapping counter; simultaneous up and down pulses cancel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else if (press_pulse[0] && !press_pulse[1]) begin
      count_q <= (count_q == MAX_COUNT) ? '0 : count_q + CNT_WIDTH'(1);
    end else if (press_pulse[1] && !press_pulse[0]) begin
      count_q <= (count_q == '0) ? MAX_COUNT : count_q - CNT_WIDTH'(1);
    end
  end

  // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd_work;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_work[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_work[4*d +: 4] + 4'd3;
    end
  end

  // Double-dabble sequencer: snapshot the count, shift once per cycle, then publish all digits at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      bcd_work <= '0;
      bin_work <= '0;
      snapshot <= '0;
      iter     <= '0;
      bcd_reg  <= '0;
      o_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count_q != snapshot) begin
            bin_work <= count_q;
            bcd_work <= '0;
            snapshot <= count_q;
            iter     <= '0;
            o_busy   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_work <= {bcd_adj[BCD_W-2:0], bin_work[CNT_WIDTH-1]};
          bin_work <= {bin_work[CNT_WIDTH-2:0], 1'b0};
          iter     <= iter + IT_W'(1);
          if (iter == IT_W'(CNT_WIDTH - 1)) state <= LATCH;
        end
        LATCH: begin
          bcd_reg <= bcd_work;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Scan prescaler and digit index; the index steps once per SCAN_DIV cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prescale <= '0;
      scan_idx <= '0;
    end else if (prescale == PS_W'(SCAN_DIV - 1)) begin
      prescale <= '0;
      scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      prescale <= prescale + PS_W'(1);
    end
  end

  // Select the scanned digit, apply leading-zero blanking and pin polarities.
  always_comb begin
    cur_nibble = '0;
    cur_blank  = 1'b0;
    sel_next   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        cur_nibble  = bcd_reg[4*k +: 4];
        sel_next[k] = 1'b1;
        if (k > 0) cur_blank = i_blankLZ && ((bcd_reg >> (4 * k)) == '0);
      end
    end
    cur_seg  = cur_blank ? 7'h00 : seg7_decode(cur_nibble);
    led_next = SEG_ACTIVE_LOW ? ~{1'b0, cur_seg} : {1'b0, cur_seg};
    if (DIG_ACTIVE_LOW) sel_next = ~sel_next;
  end

  // Register digit enable and segments together so they always describe the same digit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_digitSelect <= DIG_ACTIVE_LOW ? '1 : '0;
      o_LED         <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    end else begin
      o_digitSelect <= sel_next;
      o_LED         <= led_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// tb_seg7_scan_counter: directed checks of debouncing, wrap-around counting,
// BCD conversion latency, digit scanning, blanking and reset behaviour.
module tb_seg7_scan_counter;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_btn;
  logic        dn_btn;
  logic        blank_lz;
  logic [13:0] count;
  logic        busy;
  logic [3:0]  digit_sel;
  logic [7:0]  led;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_len;
  logic busy_at_change;

  seg7_scan_counter #(
    .NUM_DIGITS    (4),
    .CNT_WIDTH     (14),
    .DEBOUNCE_CYC  (DEB),
    .SCAN_DIV      (3),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_countUpClicked(up_btn),
    .i_countDnClicked(dn_btn),
    .i_blankLZ       (blank_lz),
    .o_count         (count),
    .o_busy          (busy),
    .o_digitSelect   (digit_sel),
    .o_LED           (led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clean press: hold long enough to be accepted, then release long enough to re-arm.
  task automatic applyStimulus(input logic up, input logic dn);
    up_btn = up;
    dn_btn = dn;
    tick(DEB + 4);
    up_btn = 1'b0;
    dn_btn = 1'b0;
    tick(DEB + 4);
  endtask

  task automatic checkDigit(input int k, input logic [7:0] expected, input string tag);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    for (int i = 0; i < 30 && digit_sel !== want; i++) tick(1);
    checkOutput({tag, "_sel"}, 32'(digit_sel), 32'(want));
    checkOutput(tag, 32'(led), 32'(expected));
  endtask

  initial begin
    rst      = 1'b1;
    up_btn   = 1'b0;
    dn_btn   = 1'b0;
    blank_lz = 1'b0;

    // Reset state and first scanned digit
    tick(3);
    checkOutput("rst_count", 32'(count), 'h0);
    checkOutput("rst_led", 32'(led), 'hFF);
    checkOutput("rst_sel", 32'(digit_sel), 'hF);
    checkOutput("rst_busy", 32'(busy), 'h0);
    rst = 1'b0;
    tick(1);
    checkOutput("first_sel", 32'(digit_sel), 'hE);
    checkOutput("first_led", 32'(led), 'hC0);

    // Short press ignored; glitches followed by a long press count once
    up_btn = 1'b1; tick(3); up_btn = 1'b0; tick(12);
    checkOutput("short_press", 32'(count), 'd0);
    up_btn = 1'b1; tick(1); up_btn = 1'b0; tick(1);
    up_btn = 1'b1; tick(1); up_btn = 1'b0; tick(1);
    up_btn = 1'b1; tick(12); up_btn = 1'b0; tick(12);
    checkOutput("long_press", 32'(count), 'd1);

    // Wrap-around in both directions and cancelling presses
    applyStimulus(1'b0, 1'b1);
    checkOutput("down_to_0", 32'(count), 'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("down_wrap", 32'(count), 'd9999);
    applyStimulus(1'b1, 1'b0);
    checkOutput("up_wrap", 32'(count), 'd0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("up_dn_cancel", 32'(count), 'd9999);
    applyStimulus(1'b1, 1'b0);
    checkOutput("back_to_0", 32'(count), 'd0);

    // Count to 1234, measure conversion busy time, then read all four digits
    repeat (1233) applyStimulus(1'b1, 1'b0);
    tick(40);
    checkOutput("count_1233", 32'(count), 'd1233);
    up_btn = 1'b1;
    for (int i = 0; i < 30 && busy !== 1'b1; i++) tick(1);
    busy_len = 0;
    while (busy === 1'b1 && busy_len < 100) begin
      busy_len++;
      tick(1);
    end
    up_btn = 1'b0;
    tick(12);
    checkOutput("busy_cycles", 32'(busy_len), 'd15);
    checkOutput("count_1234", 32'(count), 'd1234);
    checkDigit(0, 8'h99, "d0_1234");
    checkDigit(1, 8'hB0, "d1_1234");
    checkDigit(2, 8'hA4, "d2_1234");
    checkDigit(3, 8'hF9, "d3_1234");

    // Leading-zero blanking on 7, then disabled
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    repeat (7) applyStimulus(1'b1, 1'b0);
    tick(40);
    blank_lz = 1'b1;
    tick(15);
    checkDigit(1, 8'hFF, "blank_d1");
    checkDigit(2, 8'hFF, "blank_d2");
    checkDigit(3, 8'hFF, "blank_d3");
    checkDigit(0, 8'hF8, "blank_d0");
    blank_lz = 1'b0;
    tick(15);
    checkDigit(1, 8'hC0, "noblank_d1");
    checkDigit(2, 8'hC0, "noblank_d2");
    checkDigit(3, 8'hC0, "noblank_d3");

    // Zero with blanking keeps digit 0 lit
    blank_lz = 1'b1;
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(40);
    checkDigit(0, 8'hC0, "zero_blank_d0");
    checkDigit(1, 8'hFF, "zero_blank_d1");
    blank_lz = 1'b0;

    // Reset in the middle of a conversion
    repeat (3) applyStimulus(1'b1, 1'b0);
    tick(40);
    checkDigit(0, 8'hB0, "pre_abort_d0");
    up_btn = 1'b1;
    for (int i = 0; i < 30 && busy !== 1'b1; i++) tick(1);
    tick(3);
    up_btn = 1'b0;
    checkOutput("abort_busy_before", 32'(busy), 'h1);
    checkOutput("abort_count_before", 32'(count), 'd4);
    rst = 1'b1;
    tick(1);
    checkOutput("abort_busy_after", 32'(busy), 'h0);
    rst = 1'b0;
    tick(1);
    checkOutput("abort_count_after", 32'(count), 'd0);
    checkDigit(0, 8'hC0, "abort_d0");

    // Count changes while a conversion is running; display ends on the latest value
    up_btn = 1'b1;
    for (int i = 0; i < 30 && busy !== 1'b1; i++) tick(1);
    up_btn = 1'b0;
    tick(6);
    up_btn = 1'b1;
    for (int i = 0; i < 40 && count !== 14'd2; i++) tick(1);
    busy_at_change = busy;
    up_btn = 1'b0;
    checkOutput("mid_conv_busy", 32'(busy_at_change), 'h1);
    tick(60);
    checkOutput("mid_conv_count", 32'(count), 'd2);
    checkOutput("mid_conv_idle", 32'(busy), 'h0);
    checkDigit(0, 8'hA4, "mid_conv_d0");
    checkDigit(1, 8'hC0, "mid_conv_d1");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
